// File: rtl/cplx_pkg.sv
// Shared types for the sequential complex multiplier: operand/product widths,
// the iteration counter width and the control FSM state encoding.
package cplx_pkg;

    localparam int OP_W  = 16;
    localparam int CNT_W = $clog2(OP_W);

    typedef logic signed [OP_W-1:0]   op_t;
    typedef logic signed [2*OP_W-1:0] prod_t;

    typedef enum logic [1:0] {IDLE, MUL, COMB, DONE} state_t;

endpackage

// File: rtl/seq_mul_signed.sv
// Radix-2 Booth multiplier, W x W -> 2W signed, one recoding step per 'step' cycle.
// 'start' loads the operands and clears the accumulator; W steps yield the product.
module seq_mul_signed #(
    parameter int W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  step,
    input  logic signed [W-1:0]   multiplicand,
    input  logic signed [W-1:0]   multiplier,
    output logic signed [2*W-1:0] product
);

    // One guard bit keeps acc - (-2^(W-1)) representable without wrapping.
    logic signed [W:0] mcand_q;
    logic signed [W:0] acc_q;
    logic [W-1:0]      mplr_q;
    logic              qm1_q;
    logic signed [W:0] sum_d;

    always_comb begin
        unique case ({mplr_q[0], qm1_q})
            2'b01:   sum_d = acc_q + mcand_q;
            2'b10:   sum_d = acc_q - mcand_q;
            default: sum_d = acc_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            qm1_q   <= 1'b0;
        end else if (start) begin
            mcand_q <= {multiplicand[W-1], multiplicand};
            acc_q   <= '0;
            mplr_q  <= multiplier;
            qm1_q   <= 1'b0;
        end else if (step) begin
            acc_q   <= {sum_d[W], sum_d[W:1]};
            mplr_q  <= {sum_d[0], mplr_q[W-1:1]};
            qm1_q   <= mplr_q[0];
        end
    end

    assign product = {acc_q[W-1:0], mplr_q};

endmodule

// File: rtl/cplx_mul_seq.sv
// Sequential signed complex multiplier: four parallel Booth multipliers followed
// by a single 2W-bit add/subtract pass, valid/ready handshakes on both sides.
module cplx_mul_seq
    import cplx_pkg::*;
#(
    parameter int W = OP_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [W-1:0]   a_re,
    input  logic signed [W-1:0]   a_im,
    input  logic signed [W-1:0]   b_re,
    input  logic signed [W-1:0]   b_im,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [2*W-1:0] re,
    output logic signed [2*W-1:0] im,
    output logic                  ovf_re,
    output logic                  ovf_im
);

    localparam int PW   = 2 * W;
    localparam int CntW = (W == OP_W) ? CNT_W : $clog2(W);

    state_t              state_q;
    logic [CntW-1:0]     cnt_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic signed [PW-1:0] re_q, im_q;
    logic                ovf_re_q, ovf_im_q;

    logic                start;
    logic                step;
    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [PW-1:0] sub_y, re_d, im_d;
    logic                ovf_re_d, ovf_im_d;

    assign start = in_valid && in_ready_q;
    assign step  = (state_q == MUL);

    seq_mul_signed #(.W(W)) u_mul_rr (.clk(clk), .rst(rst), .start(start), .step(step),
        .multiplicand(a_re), .multiplier(b_re), .product(p_rr));
    seq_mul_signed #(.W(W)) u_mul_ii (.clk(clk), .rst(rst), .start(start), .step(step),
        .multiplicand(a_im), .multiplier(b_im), .product(p_ii));
    seq_mul_signed #(.W(W)) u_mul_ri (.clk(clk), .rst(rst), .start(start), .step(step),
        .multiplicand(a_re), .multiplier(b_im), .product(p_ri));
    seq_mul_signed #(.W(W)) u_mul_ir (.clk(clk), .rst(rst), .start(start), .step(step),
        .multiplicand(a_im), .multiplier(b_re), .product(p_ir));

    // Subtraction as x + ~y + 1 so overflow is judged against the inverted operand.
    assign sub_y    = ~p_ii;
    assign re_d     = p_rr + sub_y + PW'(1);
    assign im_d     = p_ri + p_ir;
    assign ovf_re_d = (p_rr[PW-1] == sub_y[PW-1]) && (re_d[PW-1] != p_rr[PW-1]);
    assign ovf_im_d = (p_ri[PW-1] == p_ir[PW-1]) && (im_d[PW-1] != p_ri[PW-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            re_q        <= '0;
            im_q        <= '0;
            ovf_re_q    <= 1'b0;
            ovf_im_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= MUL;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                    end
                end
                MUL: begin
                    if (cnt_q == CntW'(W - 1)) begin
                        state_q <= COMB;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                COMB: begin
                    re_q        <= re_d;
                    im_q        <= im_d;
                    ovf_re_q    <= ovf_re_d;
                    ovf_im_q    <= ovf_im_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign re        = re_q;
    assign im        = im_q;
    assign ovf_re    = ovf_re_q;
    assign ovf_im    = ovf_im_q;

endmodule
